// File: rtl/wvb_pkg.sv
// wvb_pkg
// Shared definitions for the waveform-buffer readout path.
//   - DPRAM data width and the widths of the length/source fields sent to the host
//   - state encoding of the DPRAM arbiter
//   - small index helpers for round-robin wrap-around arithmetic
package wvb_pkg;

  localparam int DPRAM_DATA_W = 128;
  localparam int LEN_W        = 16;
  localparam int SRC_W        = 4;

  // S_IDLE  : nobody owns the DPRAM, waiting for a pending reader
  // S_GRANT : one reader owns the DPRAM but has not written yet
  // S_XFER  : the owner is writing, waiting for its run pulse
  // S_HOST  : buffer handed to the host, every reader held off
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_XFER  = 2'd2,
    S_HOST  = 2'd3
  } arb_state_t;

  // (base + off) modulo n, assuming base < n and off < n.
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

  // Next index after idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return wrap_add(idx, 1, n);
  endfunction

endpackage

// File: rtl/rr_next_select.sv
// rr_next_select
// Combinational round-robin picker: returns the first set bit of 'pending' at or
// after index 'ptr', wrapping past the top back to 0.
// Ports:
//   pending  in   N      request vector, one bit per channel
//   ptr      in   IDX_W  index that has the highest priority this round
//   sel      out  IDX_W  chosen channel (only meaningful while valid = 1)
//   valid    out  1      at least one request bit is set
module rr_next_select
  import wvb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] sel,
  output logic             valid
);

  // Scan offsets from the farthest to the nearest so that the last hit written,
  // which wins, is the one closest to ptr.
  always_comb begin
    sel   = ptr;
    valid = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      if (pending[wrap_add(int'(ptr), off, N)]) begin
        sel   = IDX_W'(wrap_add(int'(ptr), off, N));
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wvb_dpram_arbiter.sv
// wvb_dpram_arbiter
// Shares one host readout DPRAM between N_READERS wvb_reader instances. Readers are
// granted one at a time in round-robin order; the owner's write port is muxed onto
// the DPRAM through one register stage and its run/len are forwarded to the host.
// After the run, every reader is held busy until the host has drained the buffer.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   en            enable; low flushes everything back to the reset state
//   rdr_pending   per reader: header FIFO not empty (request)
//   rdr_data      per reader 128-bit write data, reader i at [128*i +: 128]
//   rdr_addr      per reader DPRAM write address
//   rdr_wren      per reader DPRAM write enable
//   rdr_len       per reader transfer length in 128-bit words
//   rdr_run       per reader one-cycle run pulse (transfer complete)
//   rdr_busy      per reader dpram_busy; 0 only for the reader currently owning the DPRAM
//   dpram_data/addr/wren   registered DPRAM write port
//   dpram_len     length of the buffered transfer
//   dpram_run     one-cycle pulse to the host: buffer ready
//   dpram_src     index of the reader that filled the buffer
//   host_busy     high while the host drains the DPRAM
module wvb_dpram_arbiter
  import wvb_pkg::*;
#(
  parameter int N_READERS         = 4,
  parameter int P_DPRAM_ADR_WIDTH = 8,
  parameter int P_GRANT_TIMEOUT   = 64
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     en,
  input  logic [N_READERS-1:0]                     rdr_pending,
  input  logic [DPRAM_DATA_W*N_READERS-1:0]        rdr_data,
  input  logic [P_DPRAM_ADR_WIDTH*N_READERS-1:0]   rdr_addr,
  input  logic [N_READERS-1:0]                     rdr_wren,
  input  logic [LEN_W*N_READERS-1:0]               rdr_len,
  input  logic [N_READERS-1:0]                     rdr_run,
  output logic [N_READERS-1:0]                     rdr_busy,
  output logic [DPRAM_DATA_W-1:0]                  dpram_data,
  output logic [P_DPRAM_ADR_WIDTH-1:0]             dpram_addr,
  output logic                                     dpram_wren,
  output logic [LEN_W-1:0]                         dpram_len,
  output logic                                     dpram_run,
  output logic [SRC_W-1:0]                         dpram_src,
  input  logic                                     host_busy
);

  localparam int IDX_W = $clog2(N_READERS);
  localparam int AW    = P_DPRAM_ADR_WIDTH;
  localparam int CNT_W = $clog2(P_GRANT_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_GRANT_TIMEOUT - 1);

  arb_state_t state, state_next;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] grant_inc;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;

  logic [CNT_W-1:0] cnt;
  logic             cnt_done;
  logic             host_seen;

  logic                    xfer_active;
  logic                    g_wren;
  logic                    g_run;
  logic [DPRAM_DATA_W-1:0] g_data;
  logic [AW-1:0]           g_addr;
  logic [LEN_W-1:0]        g_len;

  rr_next_select #(
    .N     (N_READERS),
    .IDX_W (IDX_W)
  ) u_rr_next_select (
    .pending (rdr_pending),
    .ptr     (ptr),
    .sel     (sel_idx),
    .valid   (sel_valid)
  );

  // Slice out the granted reader's signals once; everything downstream works on these.
  assign g_wren    = rdr_wren[grant];
  assign g_run     = rdr_run[grant];
  assign g_data    = rdr_data[DPRAM_DATA_W*int'(grant) +: DPRAM_DATA_W];
  assign g_addr    = rdr_addr[AW*int'(grant) +: AW];
  assign g_len     = rdr_len[LEN_W*int'(grant) +: LEN_W];
  assign grant_inc = IDX_W'(wrap_inc(int'(grant), N_READERS));

  assign xfer_active = (state == S_GRANT) || (state == S_XFER);
  assign cnt_done    = (cnt == CNT_LAST);

  // State register. en low behaves as a synchronous flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (!en) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. In S_GRANT a run beats a write, and both beat the timeout.
  // In S_HOST a high host_busy always holds the state; once it is low we leave if
  // the host has already been seen busy (drain done) or if it never showed up in
  // time (buffer treated as consumed).
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (!host_busy && sel_valid) state_next = S_GRANT;
      end
      S_GRANT: begin
        if (g_run)         state_next = S_HOST;
        else if (g_wren)   state_next = S_XFER;
        else if (cnt_done) state_next = S_IDLE;
      end
      S_XFER: begin
        if (g_run) state_next = S_HOST;
      end
      S_HOST: begin
        if (!host_busy && (host_seen || cnt_done)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: only the owner sees the DPRAM free, and only before its run.
  always_comb begin
    rdr_busy = '1;
    if (xfer_active) rdr_busy[grant] = 1'b0;
  end

  // Arbitration bookkeeping. The timeout counter restarts on every state change
  // and saturates at its last value, so it serves both S_GRANT and S_HOST.
  // The round-robin pointer moves past the owner whenever a grant ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      grant     <= '0;
      cnt       <= '0;
      host_seen <= 1'b0;
    end else if (!en) begin
      ptr       <= '0;
      grant     <= '0;
      cnt       <= '0;
      host_seen <= 1'b0;
    end else begin
      if (state_next != state) begin
        cnt <= '0;
      end else if (!cnt_done) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (state == S_HOST) begin
        if (host_busy) host_seen <= 1'b1;
      end else begin
        host_seen <= 1'b0;
      end

      if (state == S_IDLE && state_next == S_GRANT) begin
        grant <= sel_idx;
      end

      if ((state == S_GRANT || state == S_HOST) && state_next == S_IDLE) begin
        ptr <= grant_inc;
      end
    end
  end

  // Registered write mux and run path. The run pulse goes out one cycle after the
  // reader's run, which lines it up with the last muxed write when the reader
  // writes its final word in the same cycle as its run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dpram_wren <= 1'b0;
      dpram_data <= '0;
      dpram_addr <= '0;
      dpram_run  <= 1'b0;
      dpram_len  <= '0;
      dpram_src  <= '0;
    end else if (!en) begin
      dpram_wren <= 1'b0;
      dpram_data <= '0;
      dpram_addr <= '0;
      dpram_run  <= 1'b0;
      dpram_len  <= '0;
      dpram_src  <= '0;
    end else begin
      dpram_wren <= xfer_active && g_wren;
      dpram_run  <= xfer_active && g_run;
      if (xfer_active && g_wren) begin
        dpram_data <= g_data;
        dpram_addr <= g_addr;
      end
      if (xfer_active && g_run) begin
        dpram_len <= g_len;
        dpram_src <= SRC_W'(grant);
      end
    end
  end

endmodule

// File: tb/tb_wvb_dpram_arbiter.sv
// tb_wvb_dpram_arbiter
// Directed bench for the 4-reader DPRAM arbiter: single transfer, round-robin
// rotation, grant timeout, long host drain, host timeout, foreign-write rejection
// and reset in the middle of a transfer.
module tb_wvb_dpram_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int TO = 64;

  logic            clk;
  logic            rst;
  logic            en;
  logic [N-1:0]    rdr_pending;
  logic [128*N-1:0] rdr_data;
  logic [AW*N-1:0] rdr_addr;
  logic [N-1:0]    rdr_wren;
  logic [16*N-1:0] rdr_len;
  logic [N-1:0]    rdr_run;
  logic [N-1:0]    rdr_busy;
  logic [127:0]    dpram_data;
  logic [AW-1:0]   dpram_addr;
  logic            dpram_wren;
  logic [15:0]     dpram_len;
  logic            dpram_run;
  logic [3:0]      dpram_src;
  logic            host_busy;

  int n_cmp = 0;
  int n_err = 0;

  wvb_dpram_arbiter #(
    .N_READERS         (N),
    .P_DPRAM_ADR_WIDTH (AW),
    .P_GRANT_TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .rdr_pending (rdr_pending),
    .rdr_data    (rdr_data),
    .rdr_addr    (rdr_addr),
    .rdr_wren    (rdr_wren),
    .rdr_len     (rdr_len),
    .rdr_run     (rdr_run),
    .rdr_busy    (rdr_busy),
    .dpram_data  (dpram_data),
    .dpram_addr  (dpram_addr),
    .dpram_wren  (dpram_wren),
    .dpram_len   (dpram_len),
    .dpram_run   (dpram_run),
    .dpram_src   (dpram_src),
    .host_busy   (host_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock in whatever inputs are currently driven, then settle past the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] wordVal(input int idx, input int k);
    logic [31:0] w;
    w = 32'h5A00_0000 + 32'(idx * 256 + k);
    return {w, ~w, w ^ 32'h0F0F_0F0F, 32'(k)};
  endfunction

  function automatic logic [3:0] busyFor(input int idx);
    logic [3:0] b;
    b = 4'hF;
    b[idx] = 1'b0;
    return b;
  endfunction

  // One full grant: grant edge, nwords writes with run on the last word, then an
  // optional host drain (busy one cycle, then released).
  task automatic runTransfer(input int idx, input int nwords, input int len, input bit do_host);
    applyStimulus();
    checkOutput("grant_busy", rdr_busy, busyFor(idx));
    checkOutput("grant_no_wr", dpram_wren, 1'b0);
    for (int k = 0; k < nwords; k++) begin
      rdr_wren[idx] = 1'b1;
      rdr_data[128*idx +: 128] = wordVal(idx, k);
      rdr_addr[AW*idx +: AW] = AW'(idx * 16 + k);
      if (k == nwords - 1) begin
        rdr_run[idx] = 1'b1;
        rdr_len[16*idx +: 16] = 16'(len);
      end
      applyStimulus();
      checkOutput("wr_en", dpram_wren, 1'b1);
      checkOutput("wr_data", dpram_data, wordVal(idx, k));
      checkOutput("wr_addr", dpram_addr, AW'(idx * 16 + k));
      checkOutput("xfer_busy", rdr_busy, (k == nwords - 1) ? 4'hF : busyFor(idx));
      checkOutput("run_pulse", dpram_run, (k == nwords - 1) ? 1'b1 : 1'b0);
    end
    checkOutput("run_len", dpram_len, 16'(len));
    checkOutput("run_src", dpram_src, 4'(idx));
    rdr_wren[idx] = 1'b0;
    rdr_run[idx]  = 1'b0;
    if (do_host) begin
      host_busy = 1'b1;
      applyStimulus();
      checkOutput("run_single", dpram_run, 1'b0);
      checkOutput("host_no_wr", dpram_wren, 1'b0);
      checkOutput("host_busy_all", rdr_busy, 4'hF);
      host_busy = 1'b0;
      applyStimulus();
      checkOutput("release_busy", rdr_busy, 4'hF);
    end
  endtask

  task automatic flush();
    en = 1'b0;
    applyStimulus();
    checkOutput("flush_busy", rdr_busy, 4'hF);
    en = 1'b1;
  endtask

  initial begin
    int order [5];
    bit ok;
    order = '{0, 1, 2, 3, 0};

    rst = 1'b1; en = 1'b1; host_busy = 1'b0;
    rdr_pending = '0; rdr_data = '0; rdr_addr = '0;
    rdr_wren = '0; rdr_len = '0; rdr_run = '0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_busy", rdr_busy, 4'hF);
    checkOutput("rst_wren", dpram_wren, 1'b0);
    checkOutput("rst_run", dpram_run, 1'b0);
    checkOutput("rst_data", dpram_data, 128'h0);
    checkOutput("rst_len", dpram_len, 16'h0);
    checkOutput("rst_src", dpram_src, 4'h0);
    rst = 1'b0;

    $display("[TB] step 1: single reader 2, 4 words");
    rdr_pending = 4'b0100;
    runTransfer(2, 4, 4, 1'b1);
    rdr_pending = 4'b0000;
    applyStimulus();
    checkOutput("idle_after_t1", rdr_busy, 4'hF);

    $display("[TB] step 2: round robin with all pending");
    flush();
    rdr_pending = 4'hF;
    for (int t = 0; t < 5; t++) runTransfer(order[t], 3, 3, 1'b1);

    $display("[TB] step 3: grant timeout on reader 1");
    flush();
    rdr_pending = 4'b0110;
    applyStimulus();
    checkOutput("to_grant", rdr_busy, 4'b1101);
    ok = 1'b1;
    for (int i = 1; i <= TO; i++) begin
      applyStimulus();
      if (dpram_run !== 1'b0 || dpram_wren !== 1'b0) ok = 1'b0;
      if (i == TO - 1) checkOutput("to_still_granted", rdr_busy, 4'b1101);
      if (i == TO)     checkOutput("to_released", rdr_busy, 4'hF);
    end
    checkOutput("to_no_run", ok, 1'b1);
    runTransfer(2, 2, 2, 1'b0);

    $display("[TB] step 3b: host never busy, buffer timeout");
    rdr_pending = 4'b0010;
    ok = 1'b1;
    for (int i = 1; i <= TO + 1; i++) begin
      applyStimulus();
      if (dpram_run !== 1'b0) ok = 1'b0;
      if (i == TO)     checkOutput("hto_idle", rdr_busy, 4'hF);
      if (i == TO + 1) checkOutput("hto_regrant", rdr_busy, 4'b1101);
    end
    checkOutput("hto_no_run", ok, 1'b1);

    $display("[TB] step 4: long host drain");
    flush();
    rdr_pending = 4'b0011;
    runTransfer(0, 1, 1, 1'b0);
    host_busy = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 500; i++) begin
      applyStimulus();
      if (rdr_busy !== 4'hF || dpram_run !== 1'b0) ok = 1'b0;
    end
    checkOutput("drain_all_busy", ok, 1'b1);
    host_busy = 1'b0;
    applyStimulus();
    checkOutput("drain_release", rdr_busy, 4'hF);
    applyStimulus();
    checkOutput("drain_next_grant", rdr_busy, 4'b1101);

    $display("[TB] step 5: foreign writes from reader 3 are dropped");
    flush();
    rdr_pending = 4'b0001;
    rdr_wren[3] = 1'b1;
    rdr_data[384 +: 128] = {4{32'hDEAD_BEEF}};
    rdr_addr[24 +: 8] = 8'hEE;
    runTransfer(0, 3, 3, 1'b1);
    rdr_wren[3] = 1'b0;

    $display("[TB] step 6: reset in the middle of a transfer");
    flush();
    rdr_pending = 4'b0100;
    applyStimulus();
    checkOutput("mid_grant", rdr_busy, 4'b1011);
    for (int k = 0; k < 2; k++) begin
      rdr_wren[2] = 1'b1;
      rdr_data[256 +: 128] = wordVal(2, k);
      rdr_addr[16 +: 8] = AW'(32 + k);
      applyStimulus();
    end
    checkOutput("mid_wr_active", dpram_wren, 1'b1);
    rdr_data[256 +: 128] = wordVal(2, 2);
    rdr_addr[16 +: 8] = AW'(34);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_wren", dpram_wren, 1'b0);
    checkOutput("mid_rst_data", dpram_data, 128'h0);
    checkOutput("mid_rst_addr", dpram_addr, 8'h0);
    checkOutput("mid_rst_busy", rdr_busy, 4'hF);
    checkOutput("mid_rst_run", dpram_run, 1'b0);
    rdr_wren = '0;
    rdr_run  = '0;
    applyStimulus();
    applyStimulus();
    checkOutput("mid_rst_hold_run", dpram_run, 1'b0);
    rst = 1'b0;
    rdr_pending = 4'b0101;
    applyStimulus();
    checkOutput("recover_grant0", rdr_busy, 4'b1110);
    checkOutput("recover_no_run", dpram_run, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
